apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB requester that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers.
- Returns one response pulse per command, carrying read data, pslverr and a timeout flag.
- Sits between internal agents (CPU bridge, DMA, test sequencer) and an APB slave on the same pclk domain.
- Supports back-to-back transfers and bounded wait states.

Parameters:
- ADDR_WIDTH, 8, paddr/cmd_addr width.
- DATA_WIDTH, 32, pwdata/prdata/cmd_wdata/rsp_rdata width.
- TIMEOUT_CYCLES, 16, maximum consecutive ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- pclk in 1: clock, all logic on the rising edge.
- prst_n in 1: asynchronous active-low reset.
- cmd_valid in 1: command request.
- cmd_ready out 1: command accepted when cmd_valid && cmd_ready.
- cmd_write in 1: 1 = write, 0 = read.
- cmd_addr in ADDR_WIDTH: transfer address.
- cmd_wdata in DATA_WIDTH: write data (ignored for reads).
- rsp_valid out 1: single-cycle response pulse, no backpressure.
- rsp_rdata out DATA_WIDTH: read data; 0 for writes and timeouts.
- rsp_err out 1: pslverr sampled at completion, or timeout.
- rsp_timeout out 1: transfer aborted by timeout.
- psel out 1: APB select.
- penable out 1: APB enable.
- pwrite out 1: APB direction.
- paddr out ADDR_WIDTH: APB address.
- pwdata out DATA_WIDTH: APB write data.
- pready in 1: slave ready.
- prdata in DATA_WIDTH: slave read data.
- pslverr in 1: slave error.

Behaviour:
- Reset: while prst_n is low, all outputs are 0, state is IDLE and the wait counter is 0. Assertion takes effect immediately, not on a clock edge.
- Reset mid-transfer: psel/penable drop at once, no response is issued, and the command is lost.
- Outputs: all outputs are registered except cmd_ready, which is combinational from state, pready and the timeout condition.
- States:
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- Completion term: done = (state==ACCESS) && (pready || timeout_hit). timeout_hit = (TIMEOUT_CYCLES!=0) && (wait_cnt == TIMEOUT_CYCLES-1) && !pready.
- cmd_ready = (state==IDLE) || done.
- Transitions:
  - IDLE -> SETUP on accept.
  - SETUP -> ACCESS unconditionally after one cycle.
  - ACCESS -> ACCESS while !done.
  - ACCESS -> SETUP on done with accept (back-to-back, psel stays 1, penable drops for one cycle).
  - ACCESS -> IDLE on done with no accept.
- On accept: cmd_write and cmd_addr are registered into pwrite and paddr. cmd_wdata is registered into pwdata for writes; pwdata is 0 for reads.
- Address/control stability: pwrite, paddr and pwdata are held constant from SETUP through the last ACCESS cycle. In IDLE they keep their last values.
- Wait counter:
  - Cleared on entry to ACCESS.
  - Increments each ACCESS cycle with pready=0; saturates and is never compared when TIMEOUT_CYCLES=0.
  - Width: $clog2(TIMEOUT_CYCLES+1), minimum 1.
- Normal completion: on the edge where pready=1 in ACCESS, the next cycle has rsp_valid=1 and rsp_err=pslverr. rsp_rdata=prdata for reads, 0 for writes. rsp_timeout=0.
- Timeout completion: in the next cycle rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. The slave sees psel drop (or a new SETUP on back-to-back).
- Simultaneous events: if pready arrives in the same cycle timeout_hit would fire, pready wins and the transfer completes normally.
- Latency: acceptance to rsp_valid is 3 cycles with zero wait states, plus 1 cycle per wait state. Sustained throughput is one transfer per 2 cycles.
- Response outputs: rsp_valid is 0 in all other cycles. rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.

Decomposition:
- Shared package apb_pkg holds:
  - apb_state_e enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10), shared with the slave.
  - Default ADDR_WIDTH/DATA_WIDTH localparams.
- One natural sub-module: apb_wait_timer (wait counter plus timeout_hit), parameterized by TIMEOUT_CYCLES.

Test Plan:
- Single write: addr 0x10, data 0xDEADBEEF, pready tied 1 -> SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read with 2 wait states: slave returns 0x12345678 on the third ACCESS cycle -> paddr stable for 3 ACCESS cycles, rsp_valid at cycle 5 with rsp_rdata=0x12345678.
- Back-to-back: write 0x04 then read 0x04, cmd_valid held, pready=1 -> second SETUP directly follows the first ACCESS with psel continuously 1; responses at cycles 3 and 5; read returns 0xDEADBEEF from the reference slave model.
- Slave error: pslverr=1 with pready=1 on a read -> rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
- Timeout: TIMEOUT_CYCLES=4, pready held 0 -> exactly 4 ACCESS cycles, then rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0, and psel=0.
- Async reset: assert prst_n=0 mid-ACCESS between clock edges -> psel, penable and rsp_valid go 0 immediately; after release, cmd_ready=1 in IDLE and no stale response appears.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer phase encoding (also used by the slave side)
// and default bus widths.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam int APB_ADDR_WIDTH = 8;
    localparam int APB_DATA_WIDTH = 32;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait-state counter. Flags the last permitted wait cycle so the
// requester can abort a transfer whose slave never raises pready.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    input  logic pready,
    output logic timeout_hit
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (count_en && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A slave answering on the final cycle still wins over the abort.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_LAST) && !pready;

endmodule

// File: rtl/apb_master.sv
// APB requester: turns valid/ready commands into SETUP/ACCESS transfers and
// returns one registered response pulse per command.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  prst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    apb_state_e            state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic timer_clear, timer_count, timeout_hit, done, accept;

    assign timer_clear = (state_q == SETUP);
    assign timer_count = (state_q == ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk        (pclk),
        .rst_n      (prst_n),
        .clear      (timer_clear),
        .count_en   (timer_count),
        .pready     (pready),
        .timeout_hit(timeout_hit)
    );

    assign done      = (state_q == ACCESS) && (pready || timeout_hit);
    // Held low during reset so nothing can be accepted while the bus is parked.
    assign cmd_ready = prst_n && ((state_q == IDLE) || done);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d       = state_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done) state_d = accept ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_write ? cmd_wdata : '0;
        end

        if (done) begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = !pready;
            rsp_err_d     = pready ? pslverr : 1'b1;
            rsp_rdata_d   = (pready && !pwrite_q) ? prdata : '0;
        end

        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios plus random traffic against a
// behavioural APB slave and an in-order transaction-level response model.
module tb_apb_master;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TC = 4;

    logic          pclk = 1'b0;
    logic          prst_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready, pslverr;
    logic [DW-1:0] prdata;

    always #5 pclk = ~pclk;

    apb_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .pclk       (pclk),
        .prst_n     (prst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr)
    );

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic          err;
    } cmd_t;

    cmd_t          plan_q[$];
    logic [DW+1:0] exp_q[$];      // {timeout, err, rdata}
    int            due_q[$];      // cycle number in which the response must appear
    logic [DW-1:0] model_mem[256];
    logic [DW-1:0] slv_mem[256];
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;

    cmd_t cur_cmd;
    int   acc_k = 0;
    bit   slv_active = 1'b0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave: wait-state count and error come from the plan of the current transfer.
    always @(negedge pclk) begin
        if (!prst_n) begin
            pready = 1'b0;
            pslverr = 1'b0;
            slv_active = 1'b0;
        end else if (psel && !penable) begin
            pready = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata = $urandom;
            chk("setup_planned", 64'(plan_q.size() != 0), 64'd1);
            slv_active = (plan_q.size() != 0);
            if (slv_active) begin
                cur_cmd = plan_q.pop_front();
                chk("setup_paddr", 64'(paddr), 64'(cur_cmd.addr));
                chk("setup_pwrite", 64'(pwrite), 64'(cur_cmd.write));
                chk("setup_pwdata", 64'(pwdata), cur_cmd.write ? 64'(cur_cmd.wdata) : 64'd0);
            end
            acc_k = 0;
        end else if (psel && penable && slv_active) begin
            chk("access_paddr", 64'(paddr), 64'(cur_cmd.addr));
            chk("access_pwrite", 64'(pwrite), 64'(cur_cmd.write));
            chk("access_pwdata", 64'(pwdata), cur_cmd.write ? 64'(cur_cmd.wdata) : 64'd0);
            if (acc_k == cur_cmd.waits) begin
                pready = 1'b1;
                pslverr = cur_cmd.err;
                prdata = cur_cmd.write ? $urandom : slv_mem[cur_cmd.addr];
                if (cur_cmd.write && !cur_cmd.err) slv_mem[cur_cmd.addr] = cur_cmd.wdata;
            end else begin
                pready = 1'b0;
                pslverr = 1'($urandom_range(0, 1));
                prdata = $urandom;
            end
            acc_k++;
        end else begin
            pready = 1'b0;
            pslverr = 1'b0;
        end
    end

    // Response monitor: every pulse must match the oldest outstanding command.
    always @(negedge pclk) begin
        logic [DW+1:0] e;
        int due;
        if (prst_n && rsp_valid) begin
            chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                due = due_q.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e[DW-1:0]));
                chk("rsp_err", 64'(rsp_err), 64'(e[DW]));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(e[DW+1]));
                chk("rsp_cycle", 64'(cyc), 64'(due));
            end
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input logic err, input bit keep);
        cmd_t          c;
        logic [DW+1:0] e;
        bit            to;
        int            n;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        do begin
            @(negedge pclk);
            #1;
            n++;
        end while (!cmd_ready && n < 50);
        chk("cmd_accept", 64'(cmd_ready), 64'd1);
        if (cmd_ready) begin
            c.write = w;
            c.addr  = a;
            c.wdata = d;
            c.waits = waits;
            c.err   = err;
            plan_q.push_back(c);
            to = (waits >= TC);
            if (to) begin
                e = {1'b1, 1'b1, DW'(0)};
            end else begin
                e = {1'b0, err, w ? DW'(0) : model_mem[a]};
                if (w && !err) model_mem[a] = d;
            end
            exp_q.push_back(e);
            due_q.push_back(cyc + 2 + (to ? TC : waits + 1));
        end
        @(posedge pclk);
        #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit keep;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = '0;
            slv_mem[i] = '0;
        end
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;

        // Reset state
        #12;
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 64'd0);
        chk("rst_bus", 64'({pwrite, paddr, pwdata}), 64'd0);
        @(negedge pclk);
        prst_n = 1'b1;
        #1;
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        idle(2);

        // Single write, zero waits
        send(1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        idle(3);
        // Read with two wait states
        send(1'b1, 8'h20, 32'h12345678, 0, 1'b0, 1'b0);
        idle(2);
        send(1'b0, 8'h20, 32'hA5A5A5A5, 2, 1'b0, 1'b0);
        idle(5);
        // Back-to-back write then read of the same address
        send(1'b1, 8'h04, 32'hDEADBEEF, 0, 1'b0, 1'b1);
        send(1'b0, 8'h04, 32'h0, 0, 1'b0, 1'b0);
        idle(3);
        // Slave error on a read still returns prdata
        send(1'b0, 8'h10, 32'h0, 0, 1'b1, 1'b0);
        idle(3);
        // pready on the final permitted wait cycle completes normally
        send(1'b0, 8'h20, 32'h0, TC - 1, 1'b0, 1'b0);
        idle(6);

        // Timeout: bus must be released in the response cycle
        send(1'b0, 8'h30, 32'h0, TC + 2, 1'b0, 1'b0);
        repeat (6) @(negedge pclk);
        #1;
        chk("timeout_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("timeout_psel", 64'(psel), 64'd0);
        chk("timeout_penable", 64'(penable), 64'd0);
        idle(2);

        // Random traffic with gaps and back-to-back runs
        for (int i = 0; i < 60; i++) begin
            keep = 1'($urandom_range(0, 1));
            send(1'($urandom_range(0, 1)), 8'(8'h50 + $urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 6), ($urandom_range(0, 7) == 0), keep);
            if (!keep) idle($urandom_range(0, 2));
        end
        idle(1);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge pclk);
            n++;
        end
        #1;
        chk("drain_random", 64'(exp_q.size()), 64'd0);
        idle(2);

        // Asynchronous reset in the middle of ACCESS
        send(1'b0, 8'h40, 32'h0, TC + 2, 1'b0, 1'b0);
        @(negedge pclk);
        @(negedge pclk);
        #2;
        chk("pre_rst_access", 64'({psel, penable}), 64'b11);
        prst_n = 1'b0;
        #1;
        chk("mid_rst_psel", 64'(psel), 64'd0);
        chk("mid_rst_penable", 64'(penable), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        plan_q.delete();
        exp_q.delete();
        due_q.delete();
        @(negedge pclk);
        #1;
        prst_n = 1'b1;
        #1;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        idle(6);
        chk("post_rst_no_rsp", 64'(exp_q.size()), 64'd0);
        send(1'b0, 8'h52, 32'h0, 1, 1'b0, 1'b0);
        idle(6);
        chk("drain_final", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
